// File: rtl/pixel_writeback_if.sv
// Pixel write-back bus: blend-stage input channel and VRAM-writer output channel.
interface pixel_writeback_if;
  logic [7:0]  i_r;
  logic [7:0]  i_g;
  logic [7:0]  i_b;
  logic [9:0]  i_x;
  logic [8:0]  i_y;
  logic        i_stp;
  logic        i_ditherEn;
  logic        i_forceMask;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_pixel;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic        o_valid;
  logic        i_ready;
  logic        o_idle;

  // Write-back block side.
  modport slave (
    input  i_r, i_g, i_b, i_x, i_y, i_stp, i_ditherEn, i_forceMask, i_valid, i_ready,
    output o_ready, o_pixel, o_x, o_y, o_valid, o_idle
  );

  // Producer / consumer side.
  modport master (
    output i_r, i_g, i_b, i_x, i_y, i_stp, i_ditherEn, i_forceMask, i_valid, i_ready,
    input  o_ready, o_pixel, o_x, o_y, o_valid, o_idle
  );
endinterface

// File: rtl/pixel_writeback.sv
// Pixel write-back: ordered dither, clamp and 5:5:5 pack into a stage register,
// followed by a small FIFO that decouples the blend stage from the VRAM writer.
module pixel_writeback #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_rst,
  pixel_writeback_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 16 + 10 + 9;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  // 4x4 ordered-dither offset for the low two bits of the coordinates.
  function automatic logic signed [9:0] dither_off(input logic [1:0] y, input logic [1:0] x);
    logic signed [9:0] d;
    case ({y, x})
      4'd0:    d = -10'sd4;
      4'd1:    d =  10'sd0;
      4'd2:    d = -10'sd3;
      4'd3:    d =  10'sd1;
      4'd4:    d =  10'sd2;
      4'd5:    d = -10'sd2;
      4'd6:    d =  10'sd3;
      4'd7:    d = -10'sd1;
      4'd8:    d = -10'sd3;
      4'd9:    d =  10'sd1;
      4'd10:   d = -10'sd4;
      4'd11:   d =  10'sd0;
      4'd12:   d =  10'sd3;
      4'd13:   d = -10'sd1;
      4'd14:   d =  10'sd2;
      4'd15:   d = -10'sd2;
      default: d =  10'sd0;
    endcase
    return d;
  endfunction

  // Add the offset, saturate to 0..255 and keep the top five bits.
  function automatic logic [4:0] quantize(input logic [7:0] c, input logic signed [9:0] off);
    logic signed [9:0] s;
    logic [4:0]        q;
    s = $signed({2'b00, c}) + off;
    if (s < 10'sd0) begin
      q = 5'd0;
    end else if (s > 10'sd255) begin
      q = 5'd31;
    end else begin
      q = s[7:3];
    end
    return q;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [15:0]       s1_pixel_q, s1_pixel_d;
  logic [9:0]        s1_x_q,     s1_x_d;
  logic [8:0]        s1_y_q,     s1_y_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;

  logic signed [9:0] off_s;
  logic [15:0]       pix_s;
  logic              pop_s;
  logic              transfer_s;
  logic              ready_s;
  logic              accept_s;

  // Colour conversion of the incoming pixel.
  always_comb begin
    off_s = 10'sd0;
    if (bus.i_ditherEn) begin
      off_s = dither_off(bus.i_y[1:0], bus.i_x[1:0]);
    end else begin
      off_s = 10'sd0;
    end
    pix_s = {bus.i_stp | bus.i_forceMask,
             quantize(bus.i_b, off_s),
             quantize(bus.i_g, off_s),
             quantize(bus.i_r, off_s)};
  end

  // Handshakes: a pop frees a FIFO slot in the same cycle, so S1 can move while full.
  always_comb begin
    pop_s      = (count_q != ZERO_C) & bus.i_ready;
    transfer_s = s1_valid_q & ((count_q < DEPTH_C) | pop_s);
    ready_s    = ~s1_valid_q | transfer_s;
    accept_s   = bus.i_valid & ready_s;
  end

  // Next state for the stage register, FIFO storage, pointers and occupancy.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pixel_d = s1_pixel_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_pixel_d = pix_s;
      s1_x_d     = bus.i_x;
      s1_y_d     = bus.i_y;
    end else if (transfer_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (transfer_s) begin
      mem_d[wr_ptr_q] = {s1_pixel_q, s1_x_q, s1_y_q};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({transfer_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every held pixel.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= ZERO_C;
    end else begin
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Pixel payload registers; contents only matter while marked valid.
  always_ff @(posedge clk) begin
    s1_pixel_q <= s1_pixel_d;
    s1_x_q     <= s1_x_d;
    s1_y_q     <= s1_y_d;
    mem_q      <= mem_d;
  end

  assign bus.o_ready = ready_s;
  assign bus.o_valid = (count_q != ZERO_C);
  assign bus.o_idle  = ~s1_valid_q & (count_q == ZERO_C);
  assign {bus.o_pixel, bus.o_x, bus.o_y} = mem_q[rd_ptr_q];

endmodule

// File: doc/pixel_writeback.md
PIXEL_WRITEBACK -- requirements
Module: pixel_writeback

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports i_r, i_g, i_b  input  8 each  blended colour from the blend stage.
REQ-005 SHALL have port i_x  input  10  and i_y  input  9  VRAM pixel coordinates.
REQ-006 SHALL have port i_stp  input  1  semi-transparency bit of the source pixel.
REQ-007 SHALL have port i_ditherEn  input  1  enable dithering, and i_forceMask  input  1  force mask bit.
REQ-008 SHALL have port i_valid  input  1  and o_ready  output  1  input handshake.
REQ-009 SHALL have port o_pixel  output  16  packed {mask, b[4:0], g[4:0], r[4:0]}.
REQ-010 SHALL have ports o_x  output  10  and o_y  output  9  coordinates of o_pixel.
REQ-011 SHALL have port o_valid  output  1  and i_ready  input  1  output handshake to VRAM writer.
REQ-012 SHALL have port o_idle  output  1  high when no pixel is held anywhere in the block.

Function
REQ-013 SHALL accept an input pixel on a rising edge where i_valid and o_ready are both high.
REQ-014 SHALL compute, per channel, sum = channel + D[i_y[1:0]][i_x[1:0]] as 10-bit signed when i_ditherEn=1, else sum = channel.
REQ-015 SHALL use dither matrix D rows (y=0..3, x=0..3): (-4,0,-3,1), (2,-2,3,-1), (-3,1,-4,0), (3,-1,2,-2).
REQ-016 SHALL clamp sum to 0..255 (negative -> 0, >255 -> 255) and take bits [7:3] as the 5-bit channel.
REQ-017 SHALL set mask = i_stp | i_forceMask.
REQ-018 SHALL register the computed pixel and coordinates into stage register S1 on acceptance (S1_valid set).
REQ-019 SHALL transfer S1 into the FIFO tail when S1_valid and (count < FIFO_DEPTH or a pop occurs same cycle).
REQ-020 SHALL drive o_ready = !S1_valid | transfer (combinational), allowing one accept per cycle at full throughput.
REQ-021 SHALL clear S1_valid on transfer without a new accept, and keep it set when transfer and accept coincide.
REQ-022 SHALL drive o_valid = (count != 0) and o_pixel/o_x/o_y from the FIFO head entry.
REQ-023 SHALL pop the head on a rising edge where o_valid and i_ready are both high.
REQ-024 SHALL keep o_pixel/o_x/o_y stable while o_valid=1 and i_ready=0.
REQ-025 SHALL leave count unchanged on simultaneous push and pop; increment on push only; decrement on pop only.
REQ-026 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-027 SHALL never push when full without a same-cycle pop, and never pop when empty.
REQ-028 SHALL have latency 2 cycles: pixel accepted at edge N appears with o_valid=1 after edge N+1 when FIFO is empty.
REQ-029 SHALL preserve pixel order input-to-output.
REQ-030 SHALL drive o_idle = !S1_valid & (count == 0).
REQ-031 SHALL hold at most FIFO_DEPTH+1 pixels; with i_ready=0 o_ready drops after FIFO_DEPTH+1 accepts.

Reset
REQ-032 SHALL, when i_rst=1 at a rising edge, clear S1_valid, count, and both pointers, discarding all held pixels.
REQ-033 SHALL output o_valid=0, o_ready=1, o_idle=1 after reset; o_pixel/o_x/o_y value is don't-care while o_valid=0.
REQ-034 SHALL give reset priority over any simultaneous accept or pop.

Verification
REQ-035 SHALL verify: i_r=i_g=i_b=0x80, x=0,y=0, ditherEn=1 -> channel 0x7C -> 5-bit 15; o_pixel=0x3DEF, o_valid 2 cycles after accept.
REQ-036 SHALL verify clamps: i_r=0x01 at (x=0,y=0) dither -> 0; i_r=0xFE at (x=3,y=1)? no: at (x=2,y=1) +3 -> 255 -> r=31.
REQ-037 SHALL verify: ditherEn=0, i_r=0xFF,i_g=0,i_b=0x08, i_stp=0, i_forceMask=1 -> o_pixel=0x841F.
REQ-038 SHALL verify backpressure with FIFO_DEPTH=4: i_ready=0, stream 8 pixels -> 5 accepted, o_ready=0, then i_ready=1 -> 8 pixels out in order.
REQ-039 SHALL verify full throughput: i_valid=i_ready=1 continuously -> one pixel in and one out per cycle, count constant.
REQ-040 SHALL verify reset mid-stream with 3 pixels held -> next cycle o_valid=0, o_idle=1, o_ready=1; no stale pixel emitted after.
